// File: rtl/servo_pwm_pkg.sv
// Shared constants, position codes and decoder FSM states for the servo PWM generator/decoder pair.
package servo_pwm_pkg;

  localparam int unsigned DefPeriodCycles = 1_000_000;
  localparam int unsigned DefW0Cycles     = 50_000;
  localparam int unsigned DefW1Cycles     = 150_000;
  localparam int unsigned DefW2Cycles     = 250_000;
  localparam int unsigned DefTolCycles    = 10_000;

  localparam logic [1:0] POS_0       = 2'b00;
  localparam logic [1:0] POS_1       = 2'b01;
  localparam logic [1:0] POS_2       = 2'b10;
  localparam logic [1:0] POS_INVALID = 2'b11;

  typedef enum logic [1:0] {
    StWaitLow,
    StWaitRise,
    StHigh
  } state_e;

  // Inclusive window test; the lower bound is clamped so it can never underflow.
  function automatic logic in_window(input int unsigned val, input int unsigned nom,
                                     input int unsigned tol);
    int unsigned lo;
    lo = (nom > tol) ? nom - tol : 32'd0;
    return (val >= lo) && (val <= nom + tol);
  endfunction

endpackage

// File: rtl/pwm_edge_sync.sv
// Synchronizes the PWM line and produces a delayed level with aligned rise/fall pulses.
// Optional glitch filter enabled by GLITCH_FILTER_EN.
module pwm_edge_sync #(
  parameter int unsigned FILT_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic pwm_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic s1_q, s2_q, s3_q;
  logic rise_q, fall_q;
  logic lvl;

  // Flops reset high so a pulse already in progress never appears as a fresh rising edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
    end else begin
      s1_q <= pwm_i;
      s2_q <= s1_q;
    end
  end

`ifdef GLITCH_FILTER_EN
  localparam int unsigned FiltW = $clog2(FILT_CYCLES + 1);

  logic             filt_q, filt_d;
  logic [FiltW-1:0] fcnt_q, fcnt_d;

  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    if (s2_q != filt_q) begin
      if (32'(fcnt_q) == FILT_CYCLES - 1) begin
        filt_d = s2_q;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      filt_q <= 1'b1;
      fcnt_q <= '0;
    end else begin
      filt_q <= filt_d;
      fcnt_q <= fcnt_d;
    end
  end

  assign lvl = filt_q;
`else
  assign lvl = s2_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      s3_q   <= 1'b1;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      s3_q   <= lvl;
      rise_q <= lvl & ~s3_q;
      fall_q <= ~lvl & s3_q;
    end
  end

  assign level_o = s3_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

  assert property (@(posedge clk) FILT_CYCLES >= 1);

endmodule

// File: rtl/servo_pwm_decoder.sv
// Measures servo PWM high time and decodes it to a 2-bit position code with loss detection.
// Optional glitch filter in pwm_edge_sync enabled by GLITCH_FILTER_EN.
module servo_pwm_decoder
  import servo_pwm_pkg::*;
#(
  parameter int unsigned PERIOD_CYCLES = DefPeriodCycles,
  parameter int unsigned W0_CYCLES     = DefW0Cycles,
  parameter int unsigned W1_CYCLES     = DefW1Cycles,
  parameter int unsigned W2_CYCLES     = DefW2Cycles,
  parameter int unsigned TOL_CYCLES    = DefTolCycles,
  parameter int unsigned LOST_CYCLES   = 2_000_000,
  parameter int unsigned CNT_W         = 21,
  parameter int unsigned FILT_CYCLES   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pwm_in,
  output logic [1:0]       pos,
  output logic             pos_valid,
  output logic [CNT_W-1:0] width,
  output logic             pos_err,
  output logic             signal_lost
);

  localparam logic [CNT_W-1:0] CntMax  = '1;
  localparam logic [CNT_W-1:0] HiMax   = CNT_W'(W2_CYCLES + TOL_CYCLES);
  localparam logic [CNT_W-1:0] LostCnt = CNT_W'(LOST_CYCLES);

  // Windows must be ordered and disjoint; written without subtraction to avoid underflow.
  localparam bit ParamsOk = (W0_CYCLES + 2 * TOL_CYCLES < W1_CYCLES) &&
                            (W1_CYCLES + 2 * TOL_CYCLES < W2_CYCLES) &&
                            (W2_CYCLES + TOL_CYCLES < PERIOD_CYCLES) &&
                            (CNT_W <= 32) && (LOST_CYCLES <= 32'(CntMax));

  logic level, rise, fall;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] hi_cnt_q, hi_cnt_d;
  logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
  logic             cap_vld_q, cap_vld_d;
  logic [CNT_W-1:0] cap_cnt_q, cap_cnt_d;
  logic             cap_ovf_q, cap_ovf_d;
  logic [1:0]       pos_q, pos_d;
  logic             pos_valid_q;
  logic [CNT_W-1:0] width_q, width_d;
  logic             pos_err_q, pos_err_d;
  logic             lost_q, lost_d;
  logic             m0, m1, m2, matched;

  pwm_edge_sync #(
    .FILT_CYCLES(FILT_CYCLES)
  ) u_edge_sync (
    .clk    (clk),
    .rst    (rst),
    .pwm_i  (pwm_in),
    .level_o(level),
    .rise_o (rise),
    .fall_o (fall)
  );

  always_comb begin
    state_d   = state_q;
    hi_cnt_d  = hi_cnt_q;
    cap_vld_d = 1'b0;
    cap_cnt_d = cap_cnt_q;
    cap_ovf_d = cap_ovf_q;
    unique case (state_q)
      StWaitLow: begin
        if (!level) state_d = StWaitRise;
      end
      StWaitRise: begin
        if (rise) begin
          state_d  = StHigh;
          hi_cnt_d = CNT_W'(1);
        end
      end
      StHigh: begin
        if (hi_cnt_q > HiMax) begin
          // Too long for any code: report now and ignore the eventual falling edge.
          cap_vld_d = 1'b1;
          cap_cnt_d = hi_cnt_q;
          cap_ovf_d = 1'b1;
          state_d   = StWaitLow;
        end else if (fall) begin
          cap_vld_d = 1'b1;
          cap_cnt_d = hi_cnt_q;
          cap_ovf_d = 1'b0;
          state_d   = StWaitRise;
        end else if (level && hi_cnt_q != CntMax) begin
          hi_cnt_d = hi_cnt_q + 1'b1;
        end
      end
      default: state_d = StWaitLow;
    endcase
  end

  always_comb begin
    m0      = in_window(32'(cap_cnt_q), W0_CYCLES, TOL_CYCLES);
    m1      = in_window(32'(cap_cnt_q), W1_CYCLES, TOL_CYCLES);
    m2      = in_window(32'(cap_cnt_q), W2_CYCLES, TOL_CYCLES);
    matched = !cap_ovf_q && (m0 || m1 || m2);

    pos_d     = pos_q;
    width_d   = width_q;
    pos_err_d = pos_err_q;
    if (cap_vld_q) begin
      width_d   = cap_cnt_q;
      pos_err_d = !matched;
      if (!matched)  pos_d = POS_INVALID;
      else if (m0)   pos_d = POS_0;
      else if (m1)   pos_d = POS_1;
      else           pos_d = POS_2;
    end

    if (rise)                      idle_cnt_d = '0;
    else if (idle_cnt_q == LostCnt) idle_cnt_d = idle_cnt_q;
    else                           idle_cnt_d = idle_cnt_q + 1'b1;

    lost_d = lost_q;
    if (idle_cnt_q == LostCnt)      lost_d = 1'b1;
    else if (cap_vld_q && matched) lost_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StWaitLow;
      hi_cnt_q    <= '0;
      idle_cnt_q  <= '0;
      cap_vld_q   <= 1'b0;
      cap_cnt_q   <= '0;
      cap_ovf_q   <= 1'b0;
      pos_q       <= POS_0;
      pos_valid_q <= 1'b0;
      width_q     <= '0;
      pos_err_q   <= 1'b0;
      lost_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      hi_cnt_q    <= hi_cnt_d;
      idle_cnt_q  <= idle_cnt_d;
      cap_vld_q   <= cap_vld_d;
      cap_cnt_q   <= cap_cnt_d;
      cap_ovf_q   <= cap_ovf_d;
      pos_q       <= pos_d;
      pos_valid_q <= cap_vld_q;
      width_q     <= width_d;
      pos_err_q   <= pos_err_d;
      lost_q      <= lost_d;
    end
  end

  assign pos         = pos_q;
  assign pos_valid   = pos_valid_q;
  assign width       = width_q;
  assign pos_err     = pos_err_q;
  assign signal_lost = lost_q;

  assert property (@(posedge clk) ParamsOk);

endmodule

// File: tb/tb_servo_pwm_decoder.sv
// Directed self-checking bench for servo_pwm_decoder using timing scaled down by 1000.
module tb_servo_pwm_decoder;

  localparam int unsigned CntW       = 12;
  localparam int unsigned FiltCycles = 4;
`ifdef GLITCH_FILTER_EN
  localparam int unsigned Lat = 4 + FiltCycles;
`else
  localparam int unsigned Lat = 4;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            pwm_in;
  logic [1:0]      pos;
  logic            pos_valid;
  logic [CntW-1:0] width;
  logic            pos_err;
  logic            signal_lost;

  int n_checks = 0;
  int n_fail   = 0;
  int n_strobe = 0;
  int base     = 0;

  logic [1:0]      s_pos    = '0;
  logic [CntW-1:0] s_width  = '0;
  logic            s_err    = 1'b0;
  logic            rst_seen = 1'b1;
  logic            armed    = 1'b0;
  logic [CntW+2:0] prev_out = '0;

  always #5 clk = ~clk;

  servo_pwm_decoder #(
    .PERIOD_CYCLES(1000),
    .W0_CYCLES    (50),
    .W1_CYCLES    (150),
    .W2_CYCLES    (250),
    .TOL_CYCLES   (10),
    .LOST_CYCLES  (2000),
    .CNT_W        (CntW),
    .FILT_CYCLES  (FiltCycles)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pwm_in     (pwm_in),
    .pos        (pos),
    .pos_valid  (pos_valid),
    .width      (width),
    .pos_err    (pos_err),
    .signal_lost(signal_lost)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Strobe recorder plus a check that outputs only move on a strobe or reset.
  always @(posedge clk) rst_seen <= rst;

  always @(negedge clk) begin
    if (pos_valid) begin
      n_strobe++;
      s_pos   = pos;
      s_width = width;
      s_err   = pos_err;
    end else if (armed && !rst_seen) begin
      check("hold_outputs", 32'({pos, width, pos_err}), 32'(prev_out));
    end
    prev_out = {pos, width, pos_err};
  end

  task automatic pulse(input int unsigned hi, input int unsigned lo);
    @(negedge clk) pwm_in = 1'b1;
    repeat (hi) @(negedge clk);
    pwm_in = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic expect_pulse(input string tag, input int exp_n, input logic [1:0] p,
                              input int unsigned w, input logic e);
    check({tag, "_count"}, 32'(n_strobe - base), 32'(exp_n));
    check({tag, "_pos"}, 32'(s_pos), 32'(p));
    check({tag, "_width"}, 32'(s_width), w);
    check({tag, "_err"}, 32'(s_err), 32'(e));
    base = n_strobe;
  endtask

  initial begin
    rst    = 1'b1;
    pwm_in = 1'b0;
    repeat (3) @(negedge clk);
    armed = 1'b1;
    check("rst_pos", 32'(pos), 32'd0);
    check("rst_valid", 32'(pos_valid), 32'd0);
    check("rst_width", 32'(width), 32'd0);
    check("rst_err", 32'(pos_err), 32'd0);
    check("rst_lost", 32'(signal_lost), 32'd1);
    rst = 1'b0;

    // Idle line: no strobes, loss flag stays set.
    repeat (1000) @(negedge clk);
    check("idle_lost_mid", 32'(signal_lost), 32'd1);
    repeat (1100) @(negedge clk);
    check("idle_lost_end", 32'(signal_lost), 32'd1);
    check("idle_strobes", 32'(n_strobe), 32'd0);

    // First frame with exact strobe latency and one-cycle width.
    @(negedge clk) pwm_in = 1'b1;
    repeat (150) @(negedge clk);
    pwm_in = 1'b0;
    repeat (Lat) @(negedge clk);
    check("lat_before", 32'(pos_valid), 32'd0);
    check("lost_before_strobe", 32'(signal_lost), 32'd1);
    @(negedge clk);
    check("lat_strobe", 32'(pos_valid), 32'd1);
    check("f1_pos", 32'(pos), 32'd1);
    check("f1_width", 32'(width), 32'd150);
    check("f1_err", 32'(pos_err), 32'd0);
    check("f1_lost_clear", 32'(signal_lost), 32'd0);
    @(negedge clk);
    check("lat_one_cycle", 32'(pos_valid), 32'd0);
    repeat (850 - Lat - 2) @(negedge clk);
    check("f1_count", 32'(n_strobe), 32'd1);
    base = n_strobe;

    for (int f = 0; f < 2; f++) begin
      pulse(150, 850);
      expect_pulse("frame", 1, 2'b01, 150, 1'b0);
    end
    check("frames_lost", 32'(signal_lost), 32'd0);

    // Silence long enough to declare loss; code is untouched.
    repeat (1200) @(negedge clk);
    check("reloss_lost", 32'(signal_lost), 32'd1);
    check("reloss_pos", 32'(pos), 32'd1);

    // Window edges around code 00.
    pulse(40, 200);
    expect_pulse("w40", 1, 2'b00, 40, 1'b0);
    check("w40_lost", 32'(signal_lost), 32'd0);
    pulse(60, 200);
    expect_pulse("w60", 1, 2'b00, 60, 1'b0);
    pulse(61, 200);
    expect_pulse("w61", 1, 2'b11, 61, 1'b1);

    // Overlong pulse: reported once while still high, nothing on the late fall.
    @(negedge clk) pwm_in = 1'b1;
    repeat (280) @(negedge clk);
    check("ovf_early_count", 32'(n_strobe - base), 32'd1);
    repeat (20) @(negedge clk);
    pwm_in = 1'b0;
    repeat (100) @(negedge clk);
    expect_pulse("ovf", 1, 2'b11, 261, 1'b1);

    // Reset in the middle of a pulse discards it; the next pulse decodes normally.
    @(negedge clk) pwm_in = 1'b1;
    repeat (100) @(negedge clk);
    rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    repeat (149) @(negedge clk);
    pwm_in = 1'b0;
    repeat (100) @(negedge clk);
    check("midrst_count", 32'(n_strobe - base), 32'd0);
    check("midrst_pos", 32'(pos), 32'd0);
    check("midrst_lost", 32'(signal_lost), 32'd1);
    pulse(250, 100);
    expect_pulse("after_rst", 1, 2'b10, 250, 1'b0);

    // Reset in the same cycle the fall is seen: no strobe.
    @(negedge clk) pwm_in = 1'b1;
    repeat (150) @(negedge clk);
    pwm_in = 1'b0;
    repeat (Lat - 1) @(negedge clk);
    rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    repeat (50) @(negedge clk);
    check("rst_at_fall_count", 32'(n_strobe - base), 32'd0);
    check("rst_at_fall_valid_pos", 32'(pos), 32'd0);

    // Two-cycle low glitch inside a 150-cycle pulse.
    @(negedge clk) pwm_in = 1'b1;
    repeat (75) @(negedge clk);
    pwm_in = 1'b0;
    repeat (2) @(negedge clk);
    pwm_in = 1'b1;
    repeat (73) @(negedge clk);
    pwm_in = 1'b0;
    repeat (100) @(negedge clk);
`ifdef GLITCH_FILTER_EN
    expect_pulse("glitch", 1, 2'b01, 150, 1'b0);
`else
    expect_pulse("glitch", 2, 2'b11, 73, 1'b1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
